// File: rtl/sdiv_pkg.sv
// Shared widths, state encoding and helpers for the sdiv signed divider.
package sdiv_pkg;

   localparam int DVD_W = 12;
   localparam int DVS_W = 7;
   localparam int REM_W = 8;
   localparam int CNT_W = 4;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);
   localparam logic [CNT_W-1:0] DZ_WAIT   = CNT_W'(2);

   localparam logic [DVD_W-1:0] QUOT_POS_SAT = 12'h7FF;
   localparam logic [DVD_W-1:0] QUOT_NEG_SAT = 12'h800;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   // 12-bit wrap makes |-2048| come out as 0x800, which is exact as unsigned.
   function automatic logic [DVD_W-1:0] magnitude(input logic [DVD_W-1:0] v);
      return v[DVD_W-1] ? (DVD_W'(0) - v) : v;
   endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore.
module sdiv_step
   import sdiv_pkg::*;
(
   input  logic [DVS_W-1:0] rem_in,
   input  logic             bit_in,
   input  logic [DVS_W-1:0] dvs,
   output logic [DVS_W-1:0] rem_out,
   output logic             q_bit
);

   logic [DVS_W:0] shifted;

   assign shifted = {rem_in, bit_in};
   assign q_bit   = (shifted >= {1'b0, dvs});
   // The difference is always below dvs, so the low bits alone are exact.
   assign rem_out = q_bit ? (shifted[DVS_W-1:0] - dvs) : shifted[DVS_W-1:0];

endmodule

// File: rtl/sdiv.sv
// Sequential signed/unsigned divider, 12 cycles of restoring division.
// Define SDIV_ROUND_EN to round the quotient magnitude to nearest.
module sdiv
   import sdiv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DVD_W-1:0] dvd,
   input  logic [DVS_W-1:0] dvs,
   output logic [DVD_W-1:0] quot,
   output logic [REM_W-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [DVD_W-1:0] mag_reg;
   logic [DVS_W-1:0] part_reg;
   logic [DVS_W-1:0] dvs_reg;
   logic             neg_reg;
   logic [DVD_W-1:0] quot_reg;
   logic [REM_W-1:0] rem_reg;
   logic             done_reg;
   logic             dz_reg;

   logic [DVS_W-1:0] step_rem;
   logic             step_q;
   logic             round_up;
   logic [DVD_W-1:0] q_mag;

   sdiv_step u_step (
      .rem_in  (part_reg),
      .bit_in  (mag_reg[DVD_W-1]),
      .dvs     (dvs_reg),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

`ifdef SDIV_ROUND_EN
   assign round_up = ({part_reg, 1'b0} >= {1'b0, dvs_reg});
`else
   assign round_up = 1'b0;
`endif

   assign q_mag = mag_reg + {{(DVD_W-1){1'b0}}, round_up};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         mag_reg   <= '0;
         part_reg  <= '0;
         dvs_reg   <= '0;
         neg_reg   <= 1'b0;
         quot_reg  <= '0;
         rem_reg   <= '0;
         done_reg  <= 1'b0;
         dz_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  mag_reg  <= magnitude(dvd);
                  dvs_reg  <= dvs;
                  neg_reg  <= dvd[DVD_W-1];
                  part_reg <= '0;
                  if (dvs == '0) begin
                     state_reg <= DONE;
                     cnt_reg   <= DZ_WAIT;
                  end else begin
                     state_reg <= CALC;
                     cnt_reg   <= LAST_STEP;
                  end
               end
            end
            CALC: begin
               // Dividend bits leave the top of mag_reg as quotient bits enter the bottom.
               part_reg <= step_rem;
               mag_reg  <= {mag_reg[DVD_W-2:0], step_q};
               if (cnt_reg == '0) begin
                  state_reg <= SIGN;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            SIGN: begin
               quot_reg  <= neg_reg ? (DVD_W'(0) - q_mag) : q_mag;
               rem_reg   <= neg_reg ? (REM_W'(0) - {1'b0, part_reg}) : {1'b0, part_reg};
               dz_reg    <= 1'b0;
               done_reg  <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               // Divide-by-zero arrives here directly and waits out a fixed two-cycle latency.
               if (done_reg) begin
                  done_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (cnt_reg <= CNT_W'(1)) begin
                  quot_reg <= neg_reg ? QUOT_NEG_SAT : QUOT_POS_SAT;
                  rem_reg  <= '0;
                  dz_reg   <= 1'b1;
                  done_reg <= 1'b1;
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign quot = quot_reg;
   assign rem  = rem_reg;
   assign dz   = dz_reg;
   assign done = done_reg;
   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_sdiv.sv
// Randomized self-checking bench for sdiv against an arithmetic reference model.
module tb_sdiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] dvd = '0;
   logic [6:0]  dvs = '0;
   logic [11:0] quot;
   logic [7:0]  rem;
   logic        busy;
   logic        done;
   logic        dz;

   sdiv dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .dvd   (dvd),
      .dvs   (dvs),
      .quot  (quot),
      .rem   (rem),
      .busy  (busy),
      .done  (done),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef SDIV_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      int          due;
      logic [11:0] q;
      logic [7:0]  r;
      logic        z;
   } exp_t;

   exp_t        pend[$];
   int          due = 0;
   int          busy_from = 1;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   logic [11:0] hold_q = '0;
   logic [7:0]  hold_r = '0;
   logic        hold_z = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: {dz, quot, rem} from plain integer division (truncates toward zero).
   function automatic logic [20:0] model(input int a, input int b);
      int q;
      int r;
      int ra;
      if (b == 0) return {1'b1, (a < 0) ? 12'h800 : 12'h7FF, 8'h00};
      q  = a / b;
      r  = a % b;
      ra = (r < 0) ? -r : r;
      if (ROUND && (2 * ra >= b)) q = (a < 0) ? q - 1 : q + 1;
      return {1'b0, q[11:0], r[7:0]};
   endfunction

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= due));
         if (done) begin
            if (pend.size() == 0 || pend[0].due != cyc) begin
               chk("done_timing", cyc, (pend.size() == 0) ? -1 : pend[0].due);
            end else begin
               chk("quot", int'(quot), int'(pend[0].q));
               chk("rem", int'(rem), int'(pend[0].r));
               chk("dz", int'(dz), int'(pend[0].z));
               hold_q = pend[0].q;
               hold_r = pend[0].r;
               hold_z = pend[0].z;
               void'(pend.pop_front());
            end
         end else begin
            if (pend.size() != 0 && pend[0].due == cyc) begin
               chk("done_missing", 0, 1);
               void'(pend.pop_front());
            end
            chk("hold", int'({dz, quot, rem}), int'({hold_z, hold_q, hold_r}));
         end
      end
   end

   task automatic wait_idle();
      while (cyc <= due) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input logic [11:0] a, input logic [6:0] b);
      logic [20:0] m;
      exp_t        e;
      m     = model($signed(a), int'(b));
      e.due = cyc + ((b == 0) ? 3 : 14);
      e.q   = m[19:8];
      e.r   = m[7:0];
      e.z   = m[20];
      busy_from = cyc + 1;
      due       = e.due;
      pend.push_back(e);
      start = 1'b1;
      dvd   = a;
      dvs   = b;
      $display("op dvd=%0d dvs=%0d -> quot=0x%03h rem=0x%02h dz=%0b", $signed(a), b, e.q, e.r, e.z);
   endtask

   task automatic run_op(input logic [11:0] a, input logic [6:0] b, input bit noise);
      wait_idle();
      if (noise) begin
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
            @(posedge clk);
            #1;
         end
      end
      launch(a, b);
      @(posedge clk);
      #1;
      start = 1'b0;
      while (cyc <= due) begin
         if (noise) begin
            dvd   = 12'($urandom);
            dvs   = 7'($urandom);
            start = ($urandom_range(0, 3) == 0);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_quot"}, int'(quot), 0);
      chk({tag, "_rem"}, int'(rem), 0);
      chk({tag, "_dz"}, int'(dz), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      logic [11:0] a;
      logic [6:0]  b;

      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      reset  = 1'b0;
      mon_en = 1'b1;

      chk("model_100_7", int'(model(100, 7)), int'({1'b0, 12'd14, 8'd2}));
      chk("model_m100_7", int'(model(-100, 7)), int'({1'b0, 12'hFF2, 8'hFE}));
      chk("model_m11_2", int'(model(-11, 2)),
          ROUND ? int'({1'b0, 12'hFFA, 8'hFF}) : int'({1'b0, 12'hFFB, 8'hFF}));
      chk("model_m2048_1", int'(model(-2048, 1)), int'({1'b0, 12'h800, 8'h00}));
      chk("model_2047_127", int'(model(2047, 127)), int'({1'b0, 12'd16, 8'd15}));
      chk("model_5_0", int'(model(5, 0)), int'({1'b1, 12'h7FF, 8'h00}));

      run_op(12'd100, 7'd7, 1'b0);
      run_op(12'hF9C, 7'd7, 1'b0);
      run_op(12'hFF5, 7'd2, 1'b0);
      run_op(12'h800, 7'd1, 1'b0);
      run_op(12'h7FF, 7'd127, 1'b0);
      run_op(12'd5, 7'd0, 1'b0);
      run_op(12'hFFB, 7'd0, 1'b1);
      run_op(12'h800, 7'd127, 1'b1);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 7))
            0:       a = 12'h800;
            1:       a = 12'h7FF;
            2:       a = 12'h000;
            default: a = 12'($urandom);
         endcase
         case ($urandom_range(0, 9))
            0:       b = 7'd0;
            1:       b = 7'd1;
            2:       b = 7'd127;
            default: b = 7'($urandom);
         endcase
         run_op(a, b, n[0]);
      end

      // Second start mid-calculation, then an abort by reset: no done may follow.
      wait_idle();
      launch(12'd100, 7'd7);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b1;
      pend.delete();
      due       = 0;
      busy_from = 1;
      hold_q    = '0;
      hold_r    = '0;
      hold_z    = 1'b0;
      #1;
      check_cleared("abort");
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
      end

      run_op(12'd100, 7'd7, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("pending_empty", pend.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
